pipelined_data_mem: RTL and testbench



---
 rtl/data_mem_pkg.sv | 18 +
 rtl/data_mem_rd_pipe.sv | 52 +++++
 rtl/pipelined_data_mem.sv | 118 +++++++++++
 tb/tb_pipelined_data_mem.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared types and limits for the pipelined data memory
package data_mem_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam int MAX_READ_LATENCY = 4;

  // Control half of a read response; the data field is added per instance
  // because its width follows DATA_WIDTH.
  typedef struct packed {
    logic valid;
    logic err;
  } rsp_meta_t;

endpackage

// File: rtl/data_mem_rd_pipe.sv
// rtl/data_mem_rd_pipe.sv - READ_LATENCY-deep response shift register with async clear
module data_mem_rd_pipe
  import data_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_err,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic                  out_err,
  output logic [DATA_WIDTH-1:0] out_data
);

  typedef struct packed {
    rsp_meta_t             meta;
    logic [DATA_WIDTH-1:0] data;
  } rsp_t;

  rsp_t stage [READ_LATENCY];

  // Valid bits shift every cycle; data/err only move with a valid response so
  // the last stage keeps the most recent response between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0].meta.valid <= in_valid;
      if (in_valid) begin
        stage[0].meta.err <= in_err;
        stage[0].data     <= in_data;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        stage[i].meta.valid <= stage[i-1].meta.valid;
        if (stage[i-1].meta.valid) begin
          stage[i].meta.err <= stage[i-1].meta.err;
          stage[i].data     <= stage[i-1].data;
        end
      end
    end
  end

  assign out_valid = stage[READ_LATENCY-1].meta.valid;
  assign out_err   = stage[READ_LATENCY-1].meta.err;
  assign out_data  = stage[READ_LATENCY-1].data;

endmodule

// File: rtl/pipelined_data_mem.sv
// rtl/pipelined_data_mem.sv - single-port data memory with zero-fill sweep and read pipeline; DATA_MEM_BYTE_EN enables byte-lane writes
module pipelined_data_mem
  import data_mem_pkg::*;
#(
  parameter  int DATA_WIDTH   = 32,
  parameter  int DEPTH        = 32,
  parameter  int READ_LATENCY = 2,
  localparam int AW           = $clog2(DEPTH),
  localparam int NB           = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [AW-1:0]         req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [NB-1:0]         req_wstrb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY || (DATA_WIDTH % 8) != 0) begin : g_bad_params
    $error("pipelined_data_mem: READ_LATENCY must be 1..4 and DATA_WIDTH a multiple of 8");
  end

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  logic [AW-1:0]         counter;
  logic                  accept;
  logic                  in_range;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;

  assign accept   = req_valid & req_ready;
  assign in_range = ({1'b0, req_addr} < DEPTH_W);
  assign wr_en    = accept & req_write & in_range;
  assign rd_en    = accept & ~req_write;
  // Out-of-range reads still respond, but with zero data.
  assign rd_data  = in_range ? mem[req_addr] : '0;

  // INIT/RUN sequencing: sweep DEPTH addresses, then open the request port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      counter   <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (counter == LAST_ADDR) begin
            state     <= RUN;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        RUN: begin
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
        default: begin
          state     <= INIT;
          counter   <= '0;
          req_ready <= 1'b0;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  // Storage: zero-fill during INIT, accepted in-range writes during RUN
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[counter] <= '0;
    end else if (wr_en) begin
`ifdef DATA_MEM_BYTE_EN
      for (int i = 0; i < NB; i++) begin
        if (req_wstrb[i]) begin
          mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
`else
      mem[req_addr] <= req_wdata;
`endif
    end
  end

`ifndef DATA_MEM_BYTE_EN
  // Lane enables are part of the port list in both builds but only matter with byte lanes.
  logic unused_wstrb;
  assign unused_wstrb = ^req_wstrb;
`endif

  data_mem_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_en),
    .in_err   (~in_range),
    .in_data  (rd_data),
    .out_valid(rsp_valid),
    .out_err  (rsp_err),
    .out_data (rsp_rdata)
  );

endmodule

// File: tb/tb_pipelined_data_mem.sv
// tb/tb_pipelined_data_mem.sv - randomized self-checking bench for pipelined_data_mem (DEPTH 32 and DEPTH 20 side by side)
module tb_pipelined_data_mem;

  localparam int L = 2;
`ifdef DATA_MEM_BYTE_EN
  localparam bit          BYTE_EN  = 1'b1;
  localparam logic [31:0] LANE_EXP = 32'h11BB33DD;
`else
  localparam bit          BYTE_EN  = 1'b0;
  localparam logic [31:0] LANE_EXP = 32'hAABBCCDD;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [4:0]  req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;

  logic        ready32, rv32, re32, done32;
  logic [31:0] rd32;
  logic        ready20, rv20, re20, done20;
  logic [31:0] rd20;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  typedef struct {
    int          due;
    logic [31:0] d32;
    logic        e32;
    logic [31:0] d20;
    logic        e20;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m32 [32];
  logic [31:0] m20 [20];

  pipelined_data_mem #(.DATA_WIDTH(32), .DEPTH(32), .READ_LATENCY(L)) u_dut32 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready32), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rv32), .rsp_rdata(rd32), .rsp_err(re32), .init_done(done32)
  );

  pipelined_data_mem #(.DATA_WIDTH(32), .DEPTH(20), .READ_LATENCY(L)) u_dut20 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready20), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rv20), .rsp_rdata(rd20), .rsp_err(re20), .init_done(done20)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (!BYTE_EN || s[i]) r[8*i +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  task automatic zero_models();
    for (int i = 0; i < 32; i++) m32[i] = '0;
    for (int i = 0; i < 20; i++) m20[i] = '0;
    q.delete();
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 5'($urandom);
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
  endtask

  // Drives one request (called only while both DUTs are ready) and updates the model.
  task automatic drive(input bit w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    int   ai;
    ai = int'(a);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    if (w) begin
      m32[ai] = merge(m32[ai], d, s);
      if (ai < 20) m20[ai] = merge(m20[ai], d, s);
    end else begin
      e.due = cyc + L;
      e.d32 = m32[ai];
      e.e32 = 1'b0;
      e.d20 = (ai < 20) ? m20[ai] : 32'h0;
      e.e20 = (ai >= 20);
      q.push_back(e);
    end
  endtask

  task automatic test_reset();
    int c0, t32, t20;
    rst = 1'b1;
    idle();
    zero_models();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({ready32, rv32, re32, rd32, done32, ready20, rv20, re20, rd20, done20} !== '0) begin
        errors++;
        $display("FAIL reset_values: got rdy=%b/%b v=%b/%b e=%b/%b d=%h/%h done=%b/%b want all 0",
                 ready32, ready20, rv32, rv20, re32, re20, rd32, rd20, done32, done20);
      end
    end
    rst = 1'b0;
    c0 = cyc; t32 = -1; t20 = -1;
    for (int k = 0; k < 100 && (t32 < 0 || t20 < 0); k++) begin
      @(negedge clk);
      if (done32 === 1'b1 && t32 < 0) t32 = cyc - c0;
      if (done20 === 1'b1 && t20 < 0) t20 = cyc - c0;
      vectors++;
      if (ready32 !== done32 || ready20 !== done20) begin
        errors++;
        $display("FAIL ready_vs_done: got rdy=%b/%b done=%b/%b want equal", ready32, ready20, done32, done20);
      end
    end
    vectors++;
    if (t32 != 32 || t20 != 20) begin
      errors++;
      $display("FAIL init_length: got %0d/%0d cycles want 32/20", t32, t20);
    end
  endtask

  task automatic test_zero_fill();
    exp_t e;
    bit   ve;
    for (int s = 0; s < 32 + L + 1; s++) begin
      @(negedge clk);
      while (q.size() != 0 && q[0].due < cyc) void'(q.pop_front());
      ve = 1'b0; if (q.size() != 0) ve = (q[0].due == cyc);
      vectors++;
      if (rv32 !== ve || rv20 !== ve) begin
        errors++; $display("FAIL zero_fill_valid cyc %0d: got %b/%b want %b", cyc, rv32, rv20, ve);
      end
      if (ve) begin
        e = q.pop_front(); vectors++;
        if ({rd32, re32, rd20, re20} !== {e.d32, e.e32, e.d20, e.e20}) begin
          errors++; $display("FAIL zero_fill_data: got %h/%b %h/%b want %h/%b %h/%b", rd32, re32, rd20, re20, e.d32, e.e32, e.d20, e.e20);
        end
      end
      if (s < 32) drive(1'b0, 5'(s), 32'h0, 4'h0); else idle();
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    bit   ve;
    for (int s = 0; s < 2 + L + 1; s++) begin
      @(negedge clk);
      while (q.size() != 0 && q[0].due < cyc) void'(q.pop_front());
      ve = 1'b0; if (q.size() != 0) ve = (q[0].due == cyc);
      vectors++;
      if (rv32 !== ve || rv20 !== ve) begin
        errors++; $display("FAIL write_read_valid cyc %0d: got %b/%b want %b", cyc, rv32, rv20, ve);
      end
      if (ve) begin
        e = q.pop_front(); vectors++;
        if (rd32 !== 32'hDEADBEEF || {rd32, re32, rd20, re20} !== {e.d32, e.e32, e.d20, e.e20}) begin
          errors++; $display("FAIL write_read_data: got %h/%b %h/%b want %h/%b %h/%b", rd32, re32, rd20, re20, e.d32, e.e32, e.d20, e.e20);
        end
      end
      if (s == 0) drive(1'b1, 5'd5, 32'hDEADBEEF, 4'hF);
      else if (s == 1) drive(1'b0, 5'd5, 32'h0, 4'h0);
      else idle();
    end
  endtask

  task automatic test_byte_lanes();
    exp_t e;
    bit   ve;
    for (int s = 0; s < 3 + L + 1; s++) begin
      @(negedge clk);
      while (q.size() != 0 && q[0].due < cyc) void'(q.pop_front());
      ve = 1'b0; if (q.size() != 0) ve = (q[0].due == cyc);
      vectors++;
      if (rv32 !== ve || rv20 !== ve) begin
        errors++; $display("FAIL byte_lane_valid cyc %0d: got %b/%b want %b", cyc, rv32, rv20, ve);
      end
      if (ve) begin
        e = q.pop_front(); vectors++;
        if (rd32 !== LANE_EXP || rd20 !== LANE_EXP || {re32, re20} !== {e.e32, e.e20}) begin
          errors++; $display("FAIL byte_lane_data: got %h/%b %h/%b want %h/0 %h/0", rd32, re32, rd20, re20, LANE_EXP, LANE_EXP);
        end
      end
      if (s == 0) drive(1'b1, 5'd7, 32'h11223344, 4'hF);
      else if (s == 1) drive(1'b1, 5'd7, 32'hAABBCCDD, 4'b0101);
      else if (s == 2) drive(1'b0, 5'd7, 32'h0, 4'h0);
      else idle();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   ve;
    int   r;
    for (int s = 0; s < 6 + 80 + L + 1; s++) begin
      @(negedge clk);
      while (q.size() != 0 && q[0].due < cyc) void'(q.pop_front());
      ve = 1'b0; if (q.size() != 0) ve = (q[0].due == cyc);
      vectors++;
      if (rv32 !== ve || rv20 !== ve) begin
        errors++; $display("FAIL stream_valid cyc %0d: got %b/%b want %b", cyc, rv32, rv20, ve);
      end
      if (ve) begin
        e = q.pop_front(); vectors++;
        if ({rd32, re32, rd20, re20} !== {e.d32, e.e32, e.d20, e.e20}) begin
          errors++; $display("FAIL stream_data cyc %0d: got %h/%b %h/%b want %h/%b %h/%b", cyc, rd32, re32, rd20, re20, e.d32, e.e32, e.d20, e.e20);
        end
      end
      if (s < 3) drive(1'b1, 5'(s + 1), $urandom, 4'hF);
      else if (s < 6) drive(1'b0, 5'(s - 2), 32'h0, 4'h0);
      else if (s < 86) begin
        r = int'($urandom_range(0, 3));
        if (r == 0) idle();
        else drive(r == 1, 5'($urandom), $urandom, 4'($urandom));
      end else idle();
    end
  endtask

  task automatic test_out_of_range();
    exp_t e;
    bit   ve;
    for (int s = 0; s < 22 + L + 1; s++) begin
      @(negedge clk);
      while (q.size() != 0 && q[0].due < cyc) void'(q.pop_front());
      ve = 1'b0; if (q.size() != 0) ve = (q[0].due == cyc);
      vectors++;
      if (rv32 !== ve || rv20 !== ve) begin
        errors++; $display("FAIL oor_valid cyc %0d: got %b/%b want %b", cyc, rv32, rv20, ve);
      end
      if (ve) begin
        e = q.pop_front(); vectors++;
        if ({rd32, re32, rd20, re20} !== {e.d32, e.e32, e.d20, e.e20}) begin
          errors++; $display("FAIL oor_data cyc %0d: got %h/%b %h/%b want %h/%b %h/%b", cyc, rd32, re32, rd20, re20, e.d32, e.e32, e.d20, e.e20);
        end
      end
      if (s == 0) drive(1'b1, 5'd25, 32'h55, 4'hF);
      else if (s == 1) drive(1'b0, 5'd25, 32'h0, 4'h0);
      else if (s < 22) drive(1'b0, 5'(s - 2), 32'h0, 4'h0);
      else idle();
    end
  endtask

  task automatic test_reset_midflight();
    exp_t e;
    bit   ve;
    int   k;
    @(negedge clk); drive(1'b1, 5'd5, 32'hCAFEF00D, 4'hF);
    @(negedge clk); drive(1'b0, 5'd5, 32'h0, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    idle();
    #1;
    vectors++;
    if ({rv32, rv20, done32, done20, ready32, ready20} !== 6'b0) begin
      errors++; $display("FAIL midflight_async: got v=%b/%b done=%b/%b rdy=%b/%b want 0", rv32, rv20, done32, done20, ready32, ready20);
    end
    zero_models();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      vectors++;
      if (rv32 !== 1'b0 || rv20 !== 1'b0) begin
        errors++; $display("FAIL midflight_flush: got %b/%b want 0/0", rv32, rv20);
      end
    end
    rst = 1'b0;
    k = 0;
    while (!(done32 === 1'b1 && done20 === 1'b1) && k < 100) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (k >= 100) begin
      errors++; $display("FAIL midflight_reinit: got timeout after %0d cycles want init_done", k);
    end
    for (int s = 0; s < 1 + L + 1; s++) begin
      if (s != 0) @(negedge clk);
      while (q.size() != 0 && q[0].due < cyc) void'(q.pop_front());
      ve = 1'b0; if (q.size() != 0) ve = (q[0].due == cyc);
      vectors++;
      if (rv32 !== ve || rv20 !== ve) begin
        errors++; $display("FAIL midflight_valid cyc %0d: got %b/%b want %b", cyc, rv32, rv20, ve);
      end
      if (ve) begin
        e = q.pop_front(); vectors++;
        if (rd32 !== 32'h0 || {rd32, re32, rd20, re20} !== {e.d32, e.e32, e.d20, e.e20}) begin
          errors++; $display("FAIL midflight_data: got %h/%b %h/%b want %h/%b %h/%b", rd32, re32, rd20, re20, e.d32, e.e32, e.d20, e.e20);
        end
      end
      if (s == 0) drive(1'b0, 5'd5, 32'h0, 4'h0); else idle();
    end
  endtask

  initial begin
    test_reset();
    test_zero_fill();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_out_of_range();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
